// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and control bundle for pipe_ctrl
// Purpose: opcode / ALU-op constants, write-select and forward encodings,
//          the 12-bit EX control bundle and its bit offsets, MD FSM states.
// Ports:   none (package).
package pipe_ctrl_pkg;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic [2:0] {
        WSEL_NONE = 3'b000,
        WSEL_PC1  = 3'b001,
        WSEL_DMEM = 3'b010,
        WSEL_ALU  = 3'b011,
        WSEL_SETX = 3'b100,
        WSEL_OVF  = 3'b101
    } wsel_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // First field is the MSB of ex_ctrl.
    typedef struct packed {
        logic imme_en;
        logic addi_en;
        logic is_bne;
        logic is_blt;
        logic is_j;
        logic is_jal;
        logic is_jr;
        logic is_bex;
        logic is_md;
        logic ovf_chk;
        logic valid;
        logic rd_to_rt;
    } ctrl_t;

    localparam int CTRL_W     = 12;
    localparam int CTRL_MD    = 3;
    localparam int CTRL_OVF   = 2;
    localparam int CTRL_VALID = 1;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// rtl/pipe_ctrl_decode.sv - combinational ID-stage decoder
// Purpose: opcode/aluop -> control bundle, source and destination addresses.
// Ports:   valid_i, opcode_i, aluop_i, rs_i/rt_i/rd_i in;
//          ctrl_o, use_a_o/use_b_o, src_a_o/src_b_o, waddr_o, reg_we_o,
//          wsel_o, dmem_wr_o, is_lw_o out.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPW     = 5,
    parameter int REGW    = 5,
    parameter int RSTATUS = 30,
    parameter int RA      = 31
) (
    input  logic            valid_i,
    input  logic [OPW-1:0]  opcode_i,
    input  logic [OPW-1:0]  aluop_i,
    input  logic [REGW-1:0] rs_i,
    input  logic [REGW-1:0] rt_i,
    input  logic [REGW-1:0] rd_i,
    output ctrl_t           ctrl_o,
    output logic            use_a_o,
    output logic            use_b_o,
    output logic [REGW-1:0] src_a_o,
    output logic [REGW-1:0] src_b_o,
    output logic [REGW-1:0] waddr_o,
    output logic            reg_we_o,
    output logic [2:0]      wsel_o,
    output logic            dmem_wr_o,
    output logic            is_lw_o
);

    logic writes;
    logic is_add_sub;
    logic is_muldiv;

    always_comb begin
        is_add_sub = (aluop_i == OPW'(ALU_ADD)) || (aluop_i == OPW'(ALU_SUB));
        is_muldiv  = (aluop_i == OPW'(ALU_MUL)) || (aluop_i == OPW'(ALU_DIV));

        ctrl_o       = '0;
        ctrl_o.valid = valid_i;
        use_a_o      = 1'b0;
        use_b_o      = 1'b0;
        src_a_o      = rs_i;
        src_b_o      = rt_i;
        waddr_o      = rd_i;
        writes       = 1'b0;
        wsel_o       = WSEL_NONE;
        dmem_wr_o    = 1'b0;
        is_lw_o      = 1'b0;

        case (opcode_i)
            OPW'(OP_R): begin
                use_a_o        = 1'b1;
                use_b_o        = 1'b1;
                writes         = 1'b1;
                wsel_o         = WSEL_ALU;
                ctrl_o.is_md   = is_muldiv;
                ctrl_o.ovf_chk = is_add_sub || is_muldiv;
            end
            OPW'(OP_J): ctrl_o.is_j = 1'b1;
            OPW'(OP_BNE), OPW'(OP_BLT): begin
                ctrl_o.is_bne   = (opcode_i == OPW'(OP_BNE));
                ctrl_o.is_blt   = (opcode_i == OPW'(OP_BLT));
                ctrl_o.rd_to_rt = 1'b1;
                use_a_o         = 1'b1;
                use_b_o         = 1'b1;
                src_b_o         = rd_i;
            end
            OPW'(OP_JAL): begin
                ctrl_o.is_jal = 1'b1;
                writes        = 1'b1;
                waddr_o       = REGW'(RA);
                wsel_o        = WSEL_PC1;
            end
            OPW'(OP_JR): begin
                ctrl_o.is_jr    = 1'b1;
                ctrl_o.rd_to_rt = 1'b1;
                use_b_o         = 1'b1;
                src_b_o         = rd_i;
            end
            OPW'(OP_ADDI): begin
                ctrl_o.imme_en = 1'b1;
                ctrl_o.addi_en = 1'b1;
                ctrl_o.ovf_chk = 1'b1;
                use_a_o        = 1'b1;
                writes         = 1'b1;
                wsel_o         = WSEL_ALU;
            end
            OPW'(OP_SW): begin
                ctrl_o.imme_en  = 1'b1;
                ctrl_o.addi_en  = 1'b1;
                ctrl_o.rd_to_rt = 1'b1;
                use_a_o         = 1'b1;
                use_b_o         = 1'b1;
                src_b_o         = rd_i;
                dmem_wr_o       = 1'b1;
            end
            OPW'(OP_LW): begin
                ctrl_o.imme_en = 1'b1;
                ctrl_o.addi_en = 1'b1;
                use_a_o        = 1'b1;
                writes         = 1'b1;
                wsel_o         = WSEL_DMEM;
                is_lw_o        = 1'b1;
            end
            OPW'(OP_SETX): begin
                writes  = 1'b1;
                waddr_o = REGW'(RSTATUS);
                wsel_o  = WSEL_SETX;
            end
            OPW'(OP_BEX): begin
                ctrl_o.is_bex = 1'b1;
                use_a_o       = 1'b1;
                src_a_o       = REGW'(RSTATUS);
            end
            default: ;
        endcase

        // Writes to r0 vanish entirely so the later stages never see them.
        reg_we_o = writes && (waddr_o != '0);
        if (!reg_we_o) begin
            waddr_o = '0;
            wsel_o  = WSEL_NONE;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipelined control unit (EX/MEM/WB bundles, hazards, MD FSM)
// Purpose: decodes ID, carries control through EX/MEM/WB, generates load-use
//          and multdiv stalls, branch flushes, forwarding and overflow writes.
// Ports:   clock/reset; id_* decode inputs; ex_branch_taken, ex_ovf, md_ready;
//          stall_fd, flush_fd, md_start, ex_ctrl, fwd_a/fwd_b,
//          mem_dmem_wr_en, wb_reg_write_en, wb_write_sel, wb_waddr.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int OPW     = 5,
    parameter int REGW    = 5,
    parameter int RSTATUS = 30,
    parameter int RA      = 31,
    parameter int FWD_EN  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [OPW-1:0]    id_opcode,
    input  logic [OPW-1:0]    id_aluop,
    input  logic [REGW-1:0]   id_rs,
    input  logic [REGW-1:0]   id_rt,
    input  logic [REGW-1:0]   id_rd,
    input  logic              ex_branch_taken,
    input  logic              ex_ovf,
    input  logic              md_ready,
    output logic              stall_fd,
    output logic              flush_fd,
    output logic              md_start,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_dmem_wr_en,
    output logic              wb_reg_write_en,
    output logic [2:0]        wb_write_sel,
    output logic [REGW-1:0]   wb_waddr
);

    ctrl_t           d_ctrl;
    logic            d_use_a, d_use_b, d_we, d_dmem_wr, d_is_lw;
    logic [REGW-1:0] d_src_a, d_src_b, d_waddr;
    logic [2:0]      d_wsel;

    ctrl_decode #(
        .OPW(OPW), .REGW(REGW), .RSTATUS(RSTATUS), .RA(RA)
    ) u_decode (
        .valid_i  (id_valid),
        .opcode_i (id_opcode),
        .aluop_i  (id_aluop),
        .rs_i     (id_rs),
        .rt_i     (id_rt),
        .rd_i     (id_rd),
        .ctrl_o   (d_ctrl),
        .use_a_o  (d_use_a),
        .use_b_o  (d_use_b),
        .src_a_o  (d_src_a),
        .src_b_o  (d_src_b),
        .waddr_o  (d_waddr),
        .reg_we_o (d_we),
        .wsel_o   (d_wsel),
        .dmem_wr_o(d_dmem_wr),
        .is_lw_o  (d_is_lw)
    );

    ctrl_t           ex_ctrl_q, ex_ctrl_d;
    logic            ex_use_a_q, ex_use_a_d, ex_use_b_q, ex_use_b_d;
    logic [REGW-1:0] ex_src_a_q, ex_src_a_d, ex_src_b_q, ex_src_b_d;
    logic [REGW-1:0] ex_waddr_q, ex_waddr_d;
    logic            ex_we_q, ex_we_d, ex_dmem_wr_q, ex_dmem_wr_d, ex_is_lw_q, ex_is_lw_d;
    logic [2:0]      ex_wsel_q, ex_wsel_d;

    logic            mem_we_q, mem_we_d, mem_dmem_wr_q, mem_dmem_wr_d;
    logic [REGW-1:0] mem_waddr_q, mem_waddr_d;
    logic [2:0]      mem_wsel_q, mem_wsel_d;

    logic            wb_we_q;
    logic [REGW-1:0] wb_waddr_q;
    logic [2:0]      wb_wsel_q;

    md_state_e       md_state_q, md_state_d;

    logic ex_valid, id_use_a, id_use_b;
    logic load_use, raw_any, hazard, md_hold, ex_bubble, ovf_take;

    function automatic logic src_hit(input logic we, input logic [REGW-1:0] wa,
                                     input logic ua, input logic [REGW-1:0] sa,
                                     input logic ub, input logic [REGW-1:0] sb);
        return we && (wa != '0) && ((ua && (wa == sa)) || (ub && (wa == sb)));
    endfunction

    assign ex_valid = ex_ctrl_q[CTRL_VALID];
    assign id_use_a = id_valid && d_use_a;
    assign id_use_b = id_valid && d_use_b;

    // Without forwarding every in-flight writer blocks a dependent reader.
    assign load_use = ex_is_lw_q &&
                      src_hit(ex_we_q, ex_waddr_q, id_use_a, d_src_a, id_use_b, d_src_b);
    assign raw_any  = src_hit(ex_we_q,  ex_waddr_q,  id_use_a, d_src_a, id_use_b, d_src_b) ||
                      src_hit(mem_we_q, mem_waddr_q, id_use_a, d_src_a, id_use_b, d_src_b) ||
                      src_hit(wb_we_q,  wb_waddr_q,  id_use_a, d_src_a, id_use_b, d_src_b);
    assign hazard   = (FWD_EN != 0) ? load_use : raw_any;

    // flush_fd is the only output fed straight from an input; gate it so the
    // whole output set reads zero while reset is held.
    assign flush_fd  = reset && ex_branch_taken;
    assign stall_fd  = md_hold || (hazard && !ex_branch_taken);
    assign ex_bubble = ex_branch_taken || hazard;
    assign ovf_take  = ex_valid && ex_ctrl_q[CTRL_OVF] && ex_ovf;

    always_comb begin
        md_state_d = md_state_q;
        md_start   = 1'b0;
        md_hold    = 1'b0;
        case (md_state_q)
            MD_IDLE: begin
                if (ex_valid && ex_ctrl_q[CTRL_MD]) begin
                    md_start   = 1'b1;
                    md_hold    = 1'b1;
                    md_state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (md_ready) md_state_d = MD_IDLE;
                else          md_hold    = 1'b1;
            end
            default: md_state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        if (id_valid && !ex_bubble) begin
            ex_ctrl_d    = d_ctrl;
            ex_use_a_d   = d_use_a;
            ex_use_b_d   = d_use_b;
            ex_src_a_d   = d_src_a;
            ex_src_b_d   = d_src_b;
            ex_waddr_d   = d_waddr;
            ex_we_d      = d_we;
            ex_wsel_d    = d_wsel;
            ex_dmem_wr_d = d_dmem_wr;
            ex_is_lw_d   = d_is_lw;
        end else begin
            ex_ctrl_d    = '0;
            ex_use_a_d   = 1'b0;
            ex_use_b_d   = 1'b0;
            ex_src_a_d   = '0;
            ex_src_b_d   = '0;
            ex_waddr_d   = '0;
            ex_we_d      = 1'b0;
            ex_wsel_d    = WSEL_NONE;
            ex_dmem_wr_d = 1'b0;
            ex_is_lw_d   = 1'b0;
        end

        mem_we_d      = ex_we_q;
        mem_waddr_d   = ex_waddr_q;
        mem_wsel_d    = ex_wsel_q;
        mem_dmem_wr_d = ex_dmem_wr_q;
        if (md_hold) begin
            mem_we_d      = 1'b0;
            mem_waddr_d   = '0;
            mem_wsel_d    = WSEL_NONE;
            mem_dmem_wr_d = 1'b0;
        end else if (ovf_take) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = REGW'(RSTATUS);
            mem_wsel_d  = WSEL_OVF;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_state_q    <= MD_IDLE;
            ex_ctrl_q     <= '0;
            ex_use_a_q    <= 1'b0;
            ex_use_b_q    <= 1'b0;
            ex_src_a_q    <= '0;
            ex_src_b_q    <= '0;
            ex_waddr_q    <= '0;
            ex_we_q       <= 1'b0;
            ex_wsel_q     <= WSEL_NONE;
            ex_dmem_wr_q  <= 1'b0;
            ex_is_lw_q    <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_waddr_q   <= '0;
            mem_wsel_q    <= WSEL_NONE;
            mem_dmem_wr_q <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_waddr_q    <= '0;
            wb_wsel_q     <= WSEL_NONE;
        end else begin
            md_state_q <= md_state_d;
            if (!md_hold) begin
                ex_ctrl_q    <= ex_ctrl_d;
                ex_use_a_q   <= ex_use_a_d;
                ex_use_b_q   <= ex_use_b_d;
                ex_src_a_q   <= ex_src_a_d;
                ex_src_b_q   <= ex_src_b_d;
                ex_waddr_q   <= ex_waddr_d;
                ex_we_q      <= ex_we_d;
                ex_wsel_q    <= ex_wsel_d;
                ex_dmem_wr_q <= ex_dmem_wr_d;
                ex_is_lw_q   <= ex_is_lw_d;
            end
            mem_we_q      <= mem_we_d;
            mem_waddr_q   <= mem_waddr_d;
            mem_wsel_q    <= mem_wsel_d;
            mem_dmem_wr_q <= mem_dmem_wr_d;
            wb_we_q       <= mem_we_q;
            wb_waddr_q    <= mem_waddr_q;
            wb_wsel_q     <= mem_wsel_q;
        end
    end

    // MEM beats WB: it holds the younger value of the register.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (FWD_EN != 0) begin
            if (ex_use_a_q) begin
                if (mem_we_q && (mem_waddr_q != '0) && (mem_waddr_q == ex_src_a_q))
                    fwd_a = FWD_MEM;
                else if (wb_we_q && (wb_waddr_q != '0) && (wb_waddr_q == ex_src_a_q))
                    fwd_a = FWD_WB;
            end
            if (ex_use_b_q) begin
                if (mem_we_q && (mem_waddr_q != '0) && (mem_waddr_q == ex_src_b_q))
                    fwd_b = FWD_MEM;
                else if (wb_we_q && (wb_waddr_q != '0) && (wb_waddr_q == ex_src_b_q))
                    fwd_b = FWD_WB;
            end
        end
    end

    assign ex_ctrl         = ex_ctrl_q;
    assign mem_dmem_wr_en  = mem_dmem_wr_q;
    assign wb_reg_write_en = wb_we_q;
    assign wb_write_sel    = wb_wsel_q;
    assign wb_waddr        = wb_waddr_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipelined control unit for the five-stage processor; the next generation of the single-cycle decoder. It decodes the ID-stage instruction into a control bundle and carries that bundle through EX/MEM/WB registers. It also generates load-use interlocks, multdiv stall handshakes, branch/jump flushes, forwarding selects and the overflow rstatus write.

Parameters:
OPW, 5, opcode and ALU-op field width
REGW, 5, register address width
RSTATUS, 30, rstatus register index (setx, bex, overflow)
RA, 31, link register index (jal)
FWD_EN, 1, 1 = drive forwarding selects; 0 = fwd_a/fwd_b held 0 and all RAW hazards on rs/rt stall

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID instruction valid
id_opcode  in  OPW  ID opcode
id_aluop  in  OPW  ID ALU op (R-type only)
id_rs  in  REGW  ID rs field
id_rt  in  REGW  ID rt field
id_rd  in  REGW  ID rd field
ex_branch_taken  in  1  EX resolved taken branch/jump/jr/bex
ex_ovf  in  1  EX arithmetic overflow
md_ready  in  1  multdiv result ready
stall_fd  out  1  hold PC and F/D register
flush_fd  out  1  squash F/D register
md_start  out  1  one-cycle multdiv start pulse
ex_ctrl  out  12  EX bundle: imme_en, addi_en, is_bne, is_blt, is_j, is_jal, is_jr, is_bex, is_md, ovf_chk, valid, rd_to_rt
fwd_a  out  2  ALU A select: 00 regfile, 01 MEM, 10 WB
fwd_b  out  2  ALU B select, same encoding
mem_dmem_wr_en  out  1  data-memory write
wb_reg_write_en  out  1  regfile write
wb_write_sel  out  3  000 none, 001 pc+1, 010 dmem, 011 ALU, 100 setx imm, 101 ovf status
wb_waddr  out  REGW  regfile write address

Behaviour:
- Reset (reset=0, asynchronous): all stage valids 0; MD state IDLE; every output 0.
- Opcodes: R 00000, j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000, setx 10101, bex 10110. R-type ALU ops: mul 00110, div 00111. Any other opcode decodes as a NOP with valid kept and no writes.
- Destination: jal -> RA; setx -> RSTATUS; R/addi/lw -> id_rd.
- Writes: j, bne, blt, sw, jr and bex never write. A write to address 0 is suppressed (reg_write_en=0).
- Sources: R -> rs, rt; addi/lw -> rs; sw/bne/blt -> rs, rd; jr -> rd; bex -> RSTATUS.
- Bundle registers: ID->EX->MEM->WB advance every cycle unless stalled. Latency from decode to wb_* is 3 cycles. Pipeline outputs are registered; stall_fd, flush_fd and fwd_* are combinational from the stage registers and ID inputs.
- Load-use hazard: EX holds a valid lw with a nonzero waddr equal to any ID source -> stall_fd=1 and a bubble (valid=0) enters EX. The ID instruction is re-decoded next cycle.
- Forwarding: for each EX source, MEM match (valid, write, nonzero address) gives 01. Otherwise a WB match gives 10. Otherwise 00. MEM has priority.
- Multdiv FSM, IDLE/BUSY:
  - IDLE: a valid is_md instruction entering EX pulses md_start for exactly that cycle, then goes to BUSY.
  - BUSY: EX held, stall_fd=1, bubbles inserted into MEM. On md_ready, EX advances next edge and the FSM returns to IDLE.
  - md_ready in IDLE is ignored.
- Branch: ex_branch_taken=1 -> flush_fd=1 and the bundle entering EX is a bubble. This has priority over load-use stall (stall_fd=0 that cycle).
- Overflow: ex_ovf=1 with EX ovf_chk (add, sub, addi, mul, div) -> the MEM bundle takes waddr=RSTATUS, write_sel=101, write_en=1.
- Mid-operation reset: aborts BUSY immediately, no md_start afterwards.

Decomposition:
- Shared package pipe_ctrl_pkg holds the opcode/ALU-op constants, the write_sel and fwd encodings, and the ctrl bundle struct with field offsets.
- One sub-module, ctrl_decode: pure combinational opcode/aluop -> ID bundle plus source/destination addresses.
- pipe_ctrl holds the stage registers, hazard/forward logic and the MD FSM.

Test Plan:
- Reset held low, then released, then addi r1,r2,5 -> wb_reg_write_en=1, wb_write_sel=011, wb_waddr=1 exactly 3 cycles after decode.
- lw r3 then add r4,r3,r5 -> stall_fd=1 for 1 cycle, a single bubble in EX, then fwd_a=10 for the add.
- mul r6,r7,r8 with md_ready after 5 cycles -> md_start=1 for one cycle, stall_fd=1 for 5 cycles, wb_waddr=6 written once.
- bne taken while the ID instruction is a lw-dependent add -> flush_fd=1, stall_fd=0, no write from the squashed instruction.
- add r9 with ex_ovf=1 -> wb_waddr=30, wb_write_sel=101. jal -> wb_waddr=31, wb_write_sel=001.
- reset asserted during BUSY -> all outputs 0 asynchronously, no md_start after release until a new mul.
